vga_bounce_overlay: RTL
=======================

# vga_bounce_overlay

Video stage between the test-pattern generator and the sync-porch stage. It reconstructs the column and row position from the active-area sync signals and draws a square box that bounces across the screen. Outside the box, incoming RGB passes through unchanged. Syncs and video leave the block re-aligned, with a fixed two-cycle latency.

## Interface
Parameters:
- VIDEO_WIDTH, 3: bits per colour channel
- TOTAL_COLS, 800: total columns per line
- TOTAL_ROWS, 525: total rows per frame
- ACTIVE_COLS, 640: visible columns
- ACTIVE_ROWS, 480: visible rows
- BOX_SIZE, 32: box edge in pixels; must be less than ACTIVE_ROWS
- SPEED, 4: pixels moved per frame on each axis; must be at least 1 and less than BOX_SIZE

Ports:
- i_Clk, input, 1: pixel clock (25 MHz)
- i_Reset, input, 1: synchronous, active-high reset
- i_Overlay_En, input, 1: 1 = draw and move the box; 0 = pass video through, position frozen
- i_HSync, input, 1: high while column < ACTIVE_COLS
- i_VSync, input, 1: high while row < ACTIVE_ROWS
- i_Red_Video, input, VIDEO_WIDTH: red channel in
- i_Grn_Video, input, VIDEO_WIDTH: green channel in
- i_Blu_Video, input, VIDEO_WIDTH: blue channel in
- o_HSync, output, 1: i_HSync delayed 2 cycles
- o_VSync, output, 1: i_VSync delayed 2 cycles
- o_Red_Video, output, VIDEO_WIDTH: red channel out, after overlay
- o_Grn_Video, output, VIDEO_WIDTH: green channel out, after overlay
- o_Blu_Video, output, VIDEO_WIDTH: blue channel out, after overlay

Clock and reset: one clock, i_Clk. Reset is synchronous and active-high (i_Reset).

## Operation
Counter reconstruction:
- A frame start is a rising edge of i_VSync (registered previous value 0, current value 1).
- On a frame start, the column and row counters load 0.
- Otherwise the column counter increments each cycle and wraps from TOTAL_COLS-1 to 0.
- The row counter increments on each column wrap and wraps from TOTAL_ROWS-1 to 0.
- Counter width is $clog2(TOTAL_COLS) for columns and $clog2(TOTAL_ROWS) for rows.

Lock:
- r_Locked clears on reset and sets on the first frame start.
- The box is drawn only while r_Locked = 1 and i_Overlay_En = 1.

Inside test: a pixel is inside the box when all of the following hold.
- col < ACTIVE_COLS and row < ACTIVE_ROWS
- X ≤ col < X+BOX_SIZE
- Y ≤ row < Y+BOX_SIZE

Colour:
- Inside pixels output all-ones on every channel (white).
- All other pixels output the delayed input video.

Motion:
- The position updates once per frame, on the falling edge of i_VSync, and only when r_Locked = 1 and i_Overlay_En = 1.
- Moving right: if X+SPEED ≥ ACTIVE_COLS-BOX_SIZE, then X ← ACTIVE_COLS-BOX_SIZE and direction becomes left; else X ← X+SPEED.
- Moving left: if X ≤ SPEED, then X ← 0 and direction becomes right; else X ← X−SPEED.
- Y follows the same rules against ACTIVE_ROWS-BOX_SIZE (directions down and up).
- X and Y update in the same cycle, independently, so both axes can bounce in the same cycle.
- The comparison X+SPEED is evaluated one bit wider than X so it cannot overflow.

Reset values:
- X = 0, Y = 0, direction right and down.
- Counters 0, r_Locked = 0.
- All outputs 0.

Reset mid-frame:
- Outputs are 0 for every cycle in which i_Reset is high.
- After reset, video passes through (box not drawn) until the next frame start.
- The box then draws at (0,0).

## Timing
- Stage 1 registers the syncs, the RGB input and the counters. The counts equal the true position of the stage-1 data.
- Stage 2 registers the overlay result and the syncs.
- Latency is exactly 2 cycles for every output. No bubbles; one pixel in and one pixel out every cycle.
- Changes to i_Overlay_En take effect on the pixel entering stage 2 on the next cycle. A change mid-frame may clip the box.
- The position update is applied at the falling edge of i_VSync. The new position is therefore stable for the entire next active frame.

## Configuration
Macro: VGA_BOUNCE_OVERLAY_BORDER_EN
- Defined: only the outline is drawn, 2 pixels thick. A pixel is drawn if it is inside the box and either:
  - col < X+2 or col ≥ X+BOX_SIZE−2, or
  - row < Y+2 or row ≥ Y+BOX_SIZE−2.
- The interior of the box passes the input video through.
- Undefined: a filled box is drawn.
- Latency and motion are identical in both builds.

## Structure
- The shared package vga_pkg holds:
  - the default timing constants (800/525/640/480)
  - the direction enum (DIR_POS, DIR_NEG)
  - a helper function for counter width
- The natural sub-module is vga_sync_to_count: frame-start detection plus the column/row counters, with registered syncs out.
- The box position FSM and the overlay multiplexer stay in the top module.

## Test plan
All scenarios use the default parameters (800/525/640/480, BOX_SIZE 32, SPEED 4, VIDEO_WIDTH 3) unless stated.
- Reset, then the first frame: all outputs 0 during reset. Frame 1 gives out pixel (col 0, row 0) = 7/7/7; pixel (32,0) and pixel (0,32) equal the input.
- Latency: feed a per-cycle incrementing red ramp with the box outside the sampled region -> o_Red_Video equals the input from 2 cycles earlier. o_HSync/o_VSync equal the inputs from 2 cycles earlier.
- Motion and horizontal bounce: after n frames X = Y = 4n. At frame 112, Y = 448, then 444 (up). At frame 152, X = 608, then 604 (left).
- Left and top bounce: force a reset, run to X = 4 moving left -> next X = 0, direction right. The same check applies to Y at the top.
- Overlay disable: drop i_Overlay_En for 3 frames at X = 40 -> output equals input exactly and X stays 40. Re-enable -> X = 44 after the next frame.
- Reset mid-frame at row 200 -> outputs 0 during reset, no box drawn for the rest of that frame, box at (0,0) on the next frame.
- Border build (VGA_BOUNCE_OVERLAY_BORDER_EN defined): pixel (1,1) is white, pixel (10,10) equals the input, pixel (31,5) is white.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: default VGA timing, box motion direction and counter width helper
package vga_pkg;
    localparam int DEF_TOTAL_COLS  = 800;
    localparam int DEF_TOTAL_ROWS  = 525;
    localparam int DEF_ACTIVE_COLS = 640;
    localparam int DEF_ACTIVE_ROWS = 480;
    typedef enum logic {DIR_POS, DIR_NEG} dir_t;
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/vga_sync_to_count.sv
// vga_sync_to_count: stage-1 sync registers and column/row counters rebuilt from active-area syncs
module vga_sync_to_count
    import vga_pkg::*;
#(
    parameter int TOTAL_COLS = DEF_TOTAL_COLS,
    parameter int TOTAL_ROWS = DEF_TOTAL_ROWS,
    localparam int CW = cnt_width(TOTAL_COLS),
    localparam int RW = cnt_width(TOTAL_ROWS)
) (
    input  logic          i_Clk,
    input  logic          i_Reset,
    input  logic          i_HSync,
    input  logic          i_VSync,
    output logic          o_HSync,
    output logic          o_VSync,
    output logic          o_Frame_Start,
    output logic          o_Frame_End,
    output logic [CW-1:0] o_Col_Count,
    output logic [RW-1:0] o_Row_Count
);
    logic r_VSync_Prev;
    assign o_Frame_Start = i_VSync & ~r_VSync_Prev;
    assign o_Frame_End   = ~i_VSync & r_VSync_Prev;
    // Edge history resets high so a reset released mid-frame is not mistaken for a frame start
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            o_HSync      <= 1'b0;
            o_VSync      <= 1'b0;
            r_VSync_Prev <= 1'b1;
            o_Col_Count  <= '0;
            o_Row_Count  <= '0;
        end else begin
            o_HSync      <= i_HSync;
            o_VSync      <= i_VSync;
            r_VSync_Prev <= i_VSync;
            if (o_Frame_Start) begin
                o_Col_Count <= '0;
                o_Row_Count <= '0;
            end else if (o_Col_Count == CW'(TOTAL_COLS - 1)) begin
                o_Col_Count <= '0;
                o_Row_Count <= (o_Row_Count == RW'(TOTAL_ROWS - 1)) ? '0 : o_Row_Count + 1'b1;
            end else begin
                o_Col_Count <= o_Col_Count + 1'b1;
            end
        end
    end
endmodule

// File: rtl/vga_bounce_overlay.sv
// vga_bounce_overlay: draws a white box bouncing once per frame over pass-through video, 2-cycle latency.
// Define VGA_BOUNCE_OVERLAY_BORDER_EN to draw only a 2-pixel outline instead of a filled box.
module vga_bounce_overlay
    import vga_pkg::*;
#(
    parameter int VIDEO_WIDTH = 3,
    parameter int TOTAL_COLS  = DEF_TOTAL_COLS,
    parameter int TOTAL_ROWS  = DEF_TOTAL_ROWS,
    parameter int ACTIVE_COLS = DEF_ACTIVE_COLS,
    parameter int ACTIVE_ROWS = DEF_ACTIVE_ROWS,
    parameter int BOX_SIZE    = 32,
    parameter int SPEED       = 4
) (
    input  logic                   i_Clk,
    input  logic                   i_Reset,
    input  logic                   i_Overlay_En,
    input  logic                   i_HSync,
    input  logic                   i_VSync,
    input  logic [VIDEO_WIDTH-1:0] i_Red_Video,
    input  logic [VIDEO_WIDTH-1:0] i_Grn_Video,
    input  logic [VIDEO_WIDTH-1:0] i_Blu_Video,
    output logic                   o_HSync,
    output logic                   o_VSync,
    output logic [VIDEO_WIDTH-1:0] o_Red_Video,
    output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
    output logic [VIDEO_WIDTH-1:0] o_Blu_Video
);
    localparam int CW = cnt_width(TOTAL_COLS);
    localparam int RW = cnt_width(TOTAL_ROWS);
    localparam logic [CW:0] X_ACT = (CW+1)'(ACTIVE_COLS);
    localparam logic [RW:0] Y_ACT = (RW+1)'(ACTIVE_ROWS);
    localparam logic [CW:0] X_BOX = (CW+1)'(BOX_SIZE);
    localparam logic [RW:0] Y_BOX = (RW+1)'(BOX_SIZE);
    localparam logic [CW:0] X_HI  = (CW+1)'(ACTIVE_COLS - BOX_SIZE);
    localparam logic [RW:0] Y_HI  = (RW+1)'(ACTIVE_ROWS - BOX_SIZE);
    localparam logic [CW:0] X_SPD = (CW+1)'(SPEED);
    localparam logic [RW:0] Y_SPD = (RW+1)'(SPEED);
    logic s1_hs, s1_vs, frame_start, frame_end, step_en, in_box, edge_px, draw;
    logic [CW-1:0] col, r_X, x_next;
    logic [RW-1:0] row, r_Y, y_next;
    logic [CW:0] cx, xx, x_fwd;
    logic [RW:0] ry, yy, y_fwd;
    logic [VIDEO_WIDTH-1:0] s1_r, s1_g, s1_b;
    dir_t r_Dir_X, r_Dir_Y, dir_x_next, dir_y_next;
    logic r_Locked;

    vga_sync_to_count #(.TOTAL_COLS(TOTAL_COLS), .TOTAL_ROWS(TOTAL_ROWS)) u_count (
        .i_Clk(i_Clk), .i_Reset(i_Reset), .i_HSync(i_HSync), .i_VSync(i_VSync),
        .o_HSync(s1_hs), .o_VSync(s1_vs), .o_Frame_Start(frame_start), .o_Frame_End(frame_end),
        .o_Col_Count(col), .o_Row_Count(row)
    );

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            s1_r     <= '0;
            s1_g     <= '0;
            s1_b     <= '0;
            r_X      <= '0;
            r_Y      <= '0;
            r_Dir_X  <= DIR_POS;
            r_Dir_Y  <= DIR_POS;
            r_Locked <= 1'b0;
        end else begin
            s1_r     <= i_Red_Video;
            s1_g     <= i_Grn_Video;
            s1_b     <= i_Blu_Video;
            r_X      <= x_next;
            r_Y      <= y_next;
            r_Dir_X  <= dir_x_next;
            r_Dir_Y  <= dir_y_next;
            r_Locked <= r_Locked | frame_start;
        end
    end

    // Position moves while the input is in vertical blanking, so a whole active frame sees one position
    always_comb begin
        x_fwd      = {1'b0, r_X} + X_SPD;
        y_fwd      = {1'b0, r_Y} + Y_SPD;
        step_en    = frame_end && r_Locked && i_Overlay_En;
        x_next     = r_X;
        y_next     = r_Y;
        dir_x_next = r_Dir_X;
        dir_y_next = r_Dir_Y;
        if (step_en) begin
            if (r_Dir_X == DIR_POS) begin
                x_next     = (x_fwd >= X_HI) ? X_HI[CW-1:0] : x_fwd[CW-1:0];
                dir_x_next = (x_fwd >= X_HI) ? DIR_NEG : DIR_POS;
            end else begin
                x_next     = ({1'b0, r_X} <= X_SPD) ? '0 : r_X - X_SPD[CW-1:0];
                dir_x_next = ({1'b0, r_X} <= X_SPD) ? DIR_POS : DIR_NEG;
            end
            if (r_Dir_Y == DIR_POS) begin
                y_next     = (y_fwd >= Y_HI) ? Y_HI[RW-1:0] : y_fwd[RW-1:0];
                dir_y_next = (y_fwd >= Y_HI) ? DIR_NEG : DIR_POS;
            end else begin
                y_next     = ({1'b0, r_Y} <= Y_SPD) ? '0 : r_Y - Y_SPD[RW-1:0];
                dir_y_next = ({1'b0, r_Y} <= Y_SPD) ? DIR_POS : DIR_NEG;
            end
        end
    end

    assign cx = {1'b0, col};
    assign ry = {1'b0, row};
    assign xx = {1'b0, r_X};
    assign yy = {1'b0, r_Y};
    assign in_box = cx < X_ACT && ry < Y_ACT && cx >= xx && cx < xx + X_BOX && ry >= yy && ry < yy + Y_BOX;
`ifdef VGA_BOUNCE_OVERLAY_BORDER_EN
    assign edge_px = cx < xx + (CW+1)'(2) || cx >= xx + X_BOX - (CW+1)'(2) ||
                     ry < yy + (RW+1)'(2) || ry >= yy + Y_BOX - (RW+1)'(2);
`else
    assign edge_px = 1'b1;
`endif
    assign draw = r_Locked && i_Overlay_En && in_box && edge_px;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            o_HSync     <= 1'b0;
            o_VSync     <= 1'b0;
            o_Red_Video <= '0;
            o_Grn_Video <= '0;
            o_Blu_Video <= '0;
        end else begin
            o_HSync     <= s1_hs;
            o_VSync     <= s1_vs;
            o_Red_Video <= draw ? '1 : s1_r;
            o_Grn_Video <= draw ? '1 : s1_g;
            o_Blu_Video <= draw ? '1 : s1_b;
        end
    end
endmodule
